// File: rtl/fir_output_normalizer_pkg.sv
// Shared types and constants for the FIR output normalizer.
package fir_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_IN_WIDTH = DEF_WIDTH + 4;

    // Width of a counter that can hold 0..in_width inclusive.
    function automatic int cnt_width(input int in_width);
        return $clog2(in_width + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_IN_WIDTH);

    // Normalizer control states; IDLE is the reset state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2,
        HOLD = 2'd3
    } norm_state_t;

endpackage

// File: rtl/fir_output_normalizer_if.sv
// Input and output handshake bundle of the FIR output normalizer.
//
// Handshake rule, both sides: a transfer happens on a rising clock edge
// where valid and ready are both high. The producer keeps its payload
// stable while valid is high and ready is low. On the output side the
// normalizer never drops out_valid or changes out_data/out_sat until the
// transfer has happened.
interface fir_output_normalizer_if #(
    parameter int WIDTH    = 16,
    parameter int IN_WIDTH = WIDTH + 4
);
    logic                in_valid;
    logic                in_ready;
    logic [IN_WIDTH-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic                out_sat;

    // Upstream FIR side plus the downstream consumer.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    // The normalizer itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/fir_output_normalizer_udiv_step.sv
// One restoring-division step: shift the next dividend bit into the
// remainder and subtract the divisor if it fits.
module fir_udiv_step #(
    parameter int RW = 21
) (
    input  logic [RW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [RW-1:0] divisor_i,
    output logic [RW-1:0] rem_o,
    output logic          q_o
);

    logic [RW:0]   trial;
    logic [RW-1:0] diff;

    // Trial subtraction; the extra top bit keeps the compare exact even if
    // the incoming remainder uses its full width.
    always_comb begin
        trial = {rem_i, bit_i};
        diff  = trial[RW-1:0] - divisor_i;
        if (trial >= {1'b0, divisor_i}) begin
            rem_o = diff;
            q_o   = 1'b1;
        end else begin
            rem_o = trial[RW-1:0];
            q_o   = 1'b0;
        end
    end

endmodule

// File: rtl/fir_output_normalizer.sv
// Sequential normalizer: divides the signed raw FIR sum by the fixed
// coefficient sum with a bit-serial restoring divider, rounds half away
// from zero and saturates to the sample width.
module fir_output_normalizer
    import fir_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int IN_WIDTH = WIDTH + 4,
    parameter int DIVISOR  = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fir_output_normalizer_if.slave  bus,
    output logic                    busy,
    output norm_state_t             dbg_state
);

    localparam int RW = IN_WIDTH + 1;
    localparam int CW = cnt_width(IN_WIDTH);

    localparam logic [RW-1:0]    DIV_V     = RW'(DIVISOR);
    localparam logic [RW-1:0]    POS_MAX   = RW'((longint'(1) << (WIDTH - 1)) - 1);
    localparam logic [RW-1:0]    NEG_MAG   = RW'(longint'(1) << (WIDTH - 1));
    localparam logic [WIDTH-1:0] POS_CLAMP = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_CLAMP = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_CNT  = CW'(IN_WIDTH - 1);

    // A divisor outside 1..2^IN_WIDTH-1 cannot be represented by the
    // remainder datapath.
    if (DIVISOR < 1 || longint'(DIVISOR) >= (longint'(1) << IN_WIDTH)) begin : g_bad_divisor
        $error("fir_output_normalizer: DIVISOR out of range");
    end

    norm_state_t         state_q, state_d;
    logic                sign_q, sign_d;
    logic [IN_WIDTH-1:0] mag_q, mag_d;
    logic [RW-1:0]       rem_q, rem_d;
    logic [IN_WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic                out_sat_q, out_sat_d;

    logic [RW-1:0]       step_rem;
    logic                step_q;
    logic                round_up;
    logic [RW-1:0]       qr;

    fir_udiv_step #(.RW(RW)) u_step (
        .rem_i     (rem_q),
        .bit_i     (mag_q[IN_WIDTH-1]),
        .divisor_i (DIV_V),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // Next-state and datapath: capture, one divide step per cycle, then
    // round/sign/saturate once and hold the result for the consumer.
    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;

        // Remainder is always below the divisor, so 2*rem fits in RW bits.
        round_up = ({rem_q[IN_WIDTH-1:0], 1'b0} >= DIV_V);
        qr       = {1'b0, quo_q} + {{(RW-1){1'b0}}, round_up};

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = DIV;
                    sign_d  = bus.in_data[IN_WIDTH-1];
                    // The most negative input negates to itself, which read
                    // as unsigned is exactly its magnitude.
                    mag_d   = bus.in_data[IN_WIDTH-1] ? -bus.in_data : bus.in_data;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                end
            end
            DIV: begin
                rem_d = step_rem;
                quo_d = {quo_q[IN_WIDTH-2:0], step_q};
                mag_d = {mag_q[IN_WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d   = HOLD;
                out_sat_d = 1'b0;
                if (!sign_q && (qr > POS_MAX)) begin
                    out_data_d = POS_CLAMP;
                    out_sat_d  = 1'b1;
                end else if (sign_q && (qr > NEG_MAG)) begin
                    out_data_d = NEG_CLAMP;
                    out_sat_d  = 1'b1;
                end else if (sign_q) begin
                    // A zero magnitude negates to zero, so no negative zero.
                    out_data_d = -qr[WIDTH-1:0];
                end else begin
                    out_data_d = qr[WIDTH-1:0];
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            mag_q      <= mag_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    // Handshake and status outputs decode directly from the state register.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == HOLD);
        bus.out_data  = out_data_q;
        bus.out_sat   = out_sat_q;
        busy          = (state_q != IDLE);
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_fir_output_normalizer.sv
// Bench for fir_output_normalizer: two instances (divisor 20 and divisor 1)
// share one stimulus stream and are checked against an arithmetic model.
module tb_fir_output_normalizer;
    import fir_pkg::*;

    localparam int W  = 16;
    localparam int IW = 20;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUTs ----------------
    logic          in_valid  = 1'b0;
    logic [IW-1:0] in_data   = '0;
    logic          out_ready = 1'b0;

    fir_output_normalizer_if #(.WIDTH(W), .IN_WIDTH(IW)) ia ();
    fir_output_normalizer_if #(.WIDTH(W), .IN_WIDTH(IW)) ib ();

    assign ia.in_valid  = in_valid;
    assign ia.in_data   = in_data;
    assign ia.out_ready = out_ready;
    assign ib.in_valid  = in_valid;
    assign ib.in_data   = in_data;
    assign ib.out_ready = out_ready;

    logic        busy_a, busy_b;
    norm_state_t st_a, st_b;

    fir_output_normalizer #(.WIDTH(W), .IN_WIDTH(IW), .DIVISOR(20)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ia),
        .busy      (busy_a),
        .dbg_state (st_a)
    );

    fir_output_normalizer #(.WIDTH(W), .IN_WIDTH(IW), .DIVISOR(1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ib),
        .busy      (busy_b),
        .dbg_state (st_b)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [W:0] exp_a_q[$];
    logic [W:0] exp_b_q[$];
    int  last_acc  = 0;
    int  last_hold = 0;
    bit  chain     = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: round-half-away-from-zero of x/div, clamped to W bits.
    function automatic logic [W:0] model(input logic [IW-1:0] d, input longint div);
        longint x, m, q, r, res, pmax, nmag;
        logic   sat;
        pmax = (longint'(1) << (W - 1)) - 1;
        nmag = longint'(1) << (W - 1);
        x = longint'($signed(d));
        m = (x < 0) ? -x : x;
        q = m / div;
        r = m % div;
        if (2 * r >= div) q = q + 1;
        sat = 1'b0;
        if (x >= 0 && q > pmax) begin
            res = pmax;
            sat = 1'b1;
        end else if (x < 0 && q > nmag) begin
            res = -nmag;
            sat = 1'b1;
        end else begin
            res = (x < 0) ? -q : q;
        end
        return {sat, res[W-1:0]};
    endfunction

    task automatic check_outputs(input string tag, input logic [W:0] ea, input logic [W:0] eb);
        check({tag, "_a_data"}, longint'($signed(ia.out_data)), longint'($signed(ea[W-1:0])));
        check({tag, "_a_sat"},  longint'(ia.out_sat), longint'(ea[W]));
        check({tag, "_b_data"}, longint'($signed(ib.out_data)), longint'($signed(eb[W-1:0])));
        check({tag, "_b_sat"},  longint'(ib.out_sat), longint'(eb[W]));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a_in_ready"},  longint'(ia.in_ready), 1);
        check({tag, "_a_out_valid"}, longint'(ia.out_valid), 0);
        check({tag, "_a_out_data"},  longint'(ia.out_data), 0);
        check({tag, "_a_out_sat"},   longint'(ia.out_sat), 0);
        check({tag, "_a_busy"},      longint'(busy_a), 0);
        check({tag, "_a_state"},     longint'(st_a), longint'(IDLE));
        check({tag, "_b_in_ready"},  longint'(ib.in_ready), 1);
        check({tag, "_b_out_valid"}, longint'(ib.out_valid), 0);
        check({tag, "_b_out_data"},  longint'(ib.out_data), 0);
        check({tag, "_b_busy"},      longint'(busy_b), 0);
    endtask

    // ---------------- driver ----------------
    // Entered and left on a falling edge. hold = cycles of out_ready=0 in HOLD.
    task automatic do_txn(input logic [IW-1:0] d, input int hold);
        int n;
        int acc_cyc;
        logic [W:0] ea, eb;
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        n = 0;
        while (!ia.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ia.in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            chain    = 1'b0;
            return;
        end
        exp_a_q.push_back(model(d, 20));
        exp_b_q.push_back(model(d, 1));
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        if (chain) check("accept_period", acc_cyc - last_acc, IW + 3 + last_hold);
        last_acc = acc_cyc;
        check("busy_after_accept", longint'(busy_a), 1);
        check("in_ready_after_accept", longint'(ia.in_ready), 0);
        n = 0;
        while (!ia.out_valid && n < 60) begin
            // valid outside IDLE must be ignored
            in_valid = 1'($urandom_range(0, 1));
            in_data  = IW'($urandom);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("latency", n, IW + 1);
        check("b_out_valid", longint'(ib.out_valid), 1);
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        check_outputs("result", ea, eb);
        if (hold > 0) begin
            in_valid = 1'b1;
            in_data  = IW'($urandom);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_out_valid", longint'(ia.out_valid), 1);
                check("hold_in_ready", longint'(ia.in_ready), 0);
                check_outputs("hold", ea, eb);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("idle_in_ready", longint'(ia.in_ready), 1);
        check("idle_out_valid", longint'(ia.out_valid), 0);
        last_hold = hold;
        chain     = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    int dir_v[13] = '{400, 29, 30, -30, -29, -9, -524288, 524287,
                      40000, -40000, -32768, 0, 100};

    initial begin
        logic [IW-1:0] v;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (dir_v[i]) do_txn(IW'(dir_v[i]), 0);

        // backpressure with in_valid high while held
        do_txn(IW'(400), 10);
        do_txn(IW'(-1234), 0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) v = IW'($urandom);
            else v = IW'($urandom_range(0, 400)) - IW'(200);
            do_txn(v, $urandom_range(0, 3));
        end

        // reset in the middle of a division
        do_txn(IW'(400), 0);
        in_data  = IW'(12345);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_div_reset");
        @(negedge clk);
        rst_n = 1'b1;
        chain = 1'b0;
        @(negedge clk);
        do_txn(IW'(100), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
